// File: rtl/jts18_pri_pkg.sv
// Shared types and constants for the System 18 VDP priority look-up controller.
// The table fill pattern puts DEFAULT_BYTE only on bytes whose lyr[6:3] field is all ones.
package jts18_pri_pkg;

    localparam int AW = 7;
    localparam logic [7:0] DEFAULT_BYTE = 8'h80;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        IDLE = 2'd1,
        ACK  = 2'd2,
        COPY = 2'd3
    } pri_state_t;

    function automatic logic [7:0] default_byte(input logic [AW-1:0] addr,
                                                input logic [7:0]    fill = DEFAULT_BYTE);
        return (addr[3:0] == 4'hF) ? fill : 8'h00;
    endfunction

endpackage

// File: rtl/jts18_pri_lut.sv
// Two 128x8 priority table banks: one shared write port, a general read port
// (CPU reads and live->shadow copy) and a dedicated live read port for pixels.
module jts18_pri_lut
    import jts18_pri_pkg::*;
#(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wr_both,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          lv_bank,
    input  logic [AW-1:0] lv_addr,
    output logic [7:0]    lv_data
);

    logic [7:0] bank0 [0:(1<<AW)-1];
    logic [7:0] bank1 [0:(1<<AW)-1];

    // wr_both lets the reset fill initialise both banks in a single pass
    always_ff @(posedge clk) begin
        if (we && (wr_both || !wr_bank)) bank0[wr_addr] <= wr_data;
        if (we && (wr_both ||  wr_bank)) bank1[wr_addr] <= wr_data;
    end

    assign rd_data = rd_bank ? bank1[rd_addr] : bank0[rd_addr];
    assign lv_data = lv_bank ? bank1[lv_addr] : bank0[lv_addr];

endmodule

// File: rtl/jts18_vdp_pri_ctl.sv
// Double-buffered priority table controller: CPU edits the shadow bank, commit swaps at vblank.
// Optional JTS18_PRI_STATUS_EN enables CPU read-back data and the st_show debug byte.
module jts18_vdp_pri_ctl
    import jts18_pri_pkg::*;
#(
    parameter int         AW      = 7,
    parameter logic [7:0] DEFAULT = 8'h80
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ack,
    input  logic          commit,
    input  logic          LVBL,
    input  logic          pxl_cen,
    input  logic [2:0]    vdp_prio,
    input  logic [6:0]    lyr,
    output logic          vdp_sel,
    output logic          busy,
    output logic [7:0]    st_show
);

    pri_state_t    state;
    logic [AW-1:0] cnt;
    logic          bank;
    logic          pending;
    logic          lvbl_l;
    logic          armed;
    logic [7:0]    dout_r;

    logic          lut_we, lut_both, lut_bank;
    logic [AW-1:0] lut_addr;
    logic [7:0]    lut_data;
    logic          rd_bank;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [AW-1:0] s1_addr;
    logic [2:0]    s1_bit;
    logic [7:0]    lv_data;

    logic lvbl_fall, accept, do_swap;

    assign lvbl_fall = lvbl_l & ~LVBL;
    assign do_swap   = (state == IDLE) && lvbl_fall && (pending || commit);
    assign accept    = (state == IDLE) && cpu_req && armed && !do_swap;
    assign busy      = (state == FILL) || (state == COPY);

    // armed re-opens only after req is seen low, so a held request is served once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FILL;
            cnt     <= '0;
            bank    <= 1'b0;
            pending <= 1'b0;
            lvbl_l  <= 1'b0;
            armed   <= 1'b1;
            cpu_ack <= 1'b0;
            dout_r  <= 8'h00;
        end else begin
            lvbl_l  <= LVBL;
            cpu_ack <= 1'b0;
            if (!cpu_req) armed   <= 1'b1;
            if (commit)   pending <= 1'b1;
            case (state)
                FILL: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) state <= IDLE;
                end
                IDLE: begin
                    if (do_swap) begin
                        bank    <= ~bank;
                        pending <= 1'b0;
                        cnt     <= '0;
                        state   <= COPY;
                    end else if (accept) begin
                        armed <= 1'b0;
                        state <= ACK;
                        if (!cpu_we) dout_r <= rd_data;
                    end
                end
                ACK: begin
                    cpu_ack <= 1'b1;
                    state   <= IDLE;
                end
                COPY: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) state <= IDLE;
                end
            endcase
        end
    end

    // COPY borrows the general read port to fetch the live byte it writes into the shadow
    always_comb begin
        lut_we   = 1'b0;
        lut_both = 1'b0;
        lut_bank = ~bank;
        lut_addr = cnt;
        lut_data = rd_data;
        rd_bank  = ~bank;
        rd_addr  = cpu_addr;
        case (state)
            FILL: begin
                lut_we   = 1'b1;
                lut_both = 1'b1;
                lut_data = default_byte(cnt, DEFAULT);
            end
            COPY: begin
                lut_we  = 1'b1;
                rd_bank = bank;
                rd_addr = cnt;
            end
            IDLE: begin
                if (accept && cpu_we) begin
                    lut_we   = 1'b1;
                    lut_addr = cpu_addr;
                    lut_data = cpu_din;
                end
            end
            default: ;
        endcase
    end

    jts18_pri_lut #(.AW(AW)) u_lut (
        .clk     (clk),
        .we      (lut_we),
        .wr_both (lut_both),
        .wr_bank (lut_bank),
        .wr_addr (lut_addr),
        .wr_data (lut_data),
        .rd_bank (rd_bank),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .lv_bank (bank),
        .lv_addr (s1_addr),
        .lv_data (lv_data)
    );

    // Two-stage lookup; the live bank is read combinationally so a swap shows immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_addr <= '0;
            s1_bit  <= 3'd0;
            vdp_sel <= 1'b0;
        end else if (pxl_cen) begin
            s1_addr <= {vdp_prio, lyr[6:3]};
            s1_bit  <= lyr[2:0];
            vdp_sel <= lv_data[s1_bit];
        end
    end

`ifdef JTS18_PRI_STATUS_EN
    assign cpu_dout = dout_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st_show <= 8'h00;
        else     st_show <= {state, pending, bank, busy, 3'b000};
    end
`else
    logic unused_dout;
    assign unused_dout = ^dout_r;
    assign cpu_dout    = 8'h00;
    assign st_show     = 8'h00;
`endif

endmodule

// File: tb/tb_jts18_vdp_pri_ctl.sv
// Scoreboard bench for jts18_vdp_pri_ctl: a table-level reference model predicts lookups,
// CPU read data and busy; monitors compare whenever the DUT presents a pixel or an ack.
module tb_jts18_vdp_pri_ctl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_req = 1'b0;
    logic       cpu_we = 1'b0;
    logic [6:0] cpu_addr = 7'd0;
    logic [7:0] cpu_din = 8'd0;
    logic [7:0] cpu_dout;
    logic       cpu_ack;
    logic       commit = 1'b0;
    logic       LVBL = 1'b1;
    logic       pxl_cen = 1'b0;
    logic [2:0] vdp_prio = 3'd0;
    logic [6:0] lyr = 7'd0;
    logic       vdp_sel;
    logic       busy;
    logic [7:0] st_show;

    always #5 clk = ~clk;

    jts18_vdp_pri_ctl dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .cpu_ack  (cpu_ack),
        .commit   (commit),
        .LVBL     (LVBL),
        .pxl_cen  (pxl_cen),
        .vdp_prio (vdp_prio),
        .lyr      (lyr),
        .vdp_sel  (vdp_sel),
        .busy     (busy),
        .st_show  (st_show)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { bit chk; bit exp; } pix_t;
    typedef struct { bit is_rd; logic [7:0] exp; } cpu_t;
    pix_t pix_q[$];
    cpu_t cpu_q[$];

    // Reference model: whole-table contents, pending flag and remaining busy cycles
    logic [7:0] live_m [128];
    logic [7:0] shad_m [128];
    bit         m_pending;
    bit         m_lvbl_l;
    int         m_busy;
    bit         last_exp;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] spec_default(input int a);
        return (a % 16 == 15) ? 8'h80 : 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) begin
            live_m[i] = spec_default(i);
            shad_m[i] = spec_default(i);
        end
        m_pending = 1'b0;
        m_lvbl_l  = 1'b0;
        m_busy    = 128;
    endtask

    // After a swap the new live table is the old shadow and the shadow is refreshed to match it
    task automatic model_edge();
        bit fall;
        if (rst) begin
            model_reset();
            return;
        end
        fall = m_lvbl_l && !LVBL;
        if (fall && (m_pending || commit) && m_busy == 0) begin
            for (int i = 0; i < 128; i++) live_m[i] = shad_m[i];
            m_pending = 1'b0;
            m_busy    = 128;
        end else begin
            if (commit) m_pending = 1'b1;
            if (m_busy > 0) m_busy--;
        end
        m_lvbl_l = LVBL;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("busy", int'(busy), (rst || m_busy > 0) ? 1 : 0);
    endtask

    // Pixel monitor: every pxl_cen edge after the first presents the previous pixel's result
    bit   have_prev = 1'b0;
    pix_t pe;
    always @(posedge clk) begin
        if (rst) begin
            have_prev = 1'b0;
            pix_q.delete();
        end else if (pxl_cen) begin
            #1;
            if (have_prev) begin
                if (pix_q.size() == 0) begin
                    check("pix_queue_empty", int'(vdp_sel), 2);
                end else begin
                    pe = pix_q.pop_front();
                    if (pe.chk) check("vdp_sel", int'(vdp_sel), int'(pe.exp));
                end
            end
            have_prev = 1'b1;
        end
    end

    // CPU monitor: each ack must match a queued access; reads compare the returned byte
    cpu_t ce;
    always @(negedge clk) begin
        if (!rst && cpu_ack) begin
            if (cpu_q.size() == 0) begin
                check("spurious_ack", int'(cpu_ack), 0);
            end else begin
                ce = cpu_q.pop_front();
                if (ce.is_rd) check("cpu_dout", int'(cpu_dout), int'(ce.exp));
            end
        end
    end

    task automatic applyStimulus_pixel(input logic [2:0] p, input logic [6:0] l, input bit chk);
        pix_t       e;
        logic [7:0] byte_v;
        int         idx, bitn;
        idx    = int'(p) * 16 + int'(l) / 8;
        bitn   = int'(l) % 8;
        byte_v = live_m[idx];
        e.chk  = chk;
        e.exp  = byte_v[bitn];
        if (chk) last_exp = e.exp;
        pix_q.push_back(e);
        vdp_prio = p;
        lyr      = l;
        pxl_cen  = 1'b1;
        tick();
        pxl_cen  = 1'b0;
    endtask

    task automatic checkOutput_lookup(input logic [2:0] p, input logic [6:0] l);
        applyStimulus_pixel(p, l, 1'b1);
        applyStimulus_pixel(3'd0, 7'd0, 1'b0);
        vdp_prio = 3'($urandom_range(0, 7));
        lyr      = 7'($urandom_range(0, 127));
        repeat (3) tick();
        check("hold", int'(vdp_sel), int'(last_exp));
    endtask

    task automatic applyStimulus_cpu(input bit we, input logic [6:0] a, input logic [7:0] d,
                                     output int lat);
        cpu_t e;
        e.is_rd = !we;
`ifdef JTS18_PRI_STATUS_EN
        e.exp = shad_m[a];
`else
        e.exp = 8'h00;
`endif
        if (we) shad_m[a] = d;
        cpu_q.push_back(e);
        cpu_req  = 1'b1;
        cpu_we   = we;
        cpu_addr = a;
        cpu_din  = d;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!cpu_ack && lat < 400);
        if (!cpu_ack) check("ack_timeout", int'(cpu_ack), 1);
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic applyStimulus_vblank();
        LVBL = 1'b0;
        repeat (2) tick();
        LVBL = 1'b1;
        tick();
    endtask

    task automatic checkOutput_reset_values(input string tag);
        check({tag, "_vdp_sel"}, int'(vdp_sel), 0);
        check({tag, "_cpu_ack"}, int'(cpu_ack), 0);
        check({tag, "_cpu_dout"}, int'(cpu_dout), 0);
        check({tag, "_busy"}, int'(busy), 1);
        check({tag, "_st_show"}, int'(st_show), 0);
    endtask

    logic [6:0] waddr [6];
    int         lat;
    int         b;

    initial begin
        model_reset();

        // Power-on reset and the 128-cycle fill
        rst = 1'b1;
        repeat (2) tick();
        checkOutput_reset_values("por");
        rst = 1'b0;
        repeat (128) tick();

        // Default table: only entry lyr=7F (bit 7 of lyr[6:3]=F bytes) selects the VDP
        checkOutput_lookup(3'd0, 7'h7F);
        checkOutput_lookup(3'd0, 7'h7E);
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 2) == 0)
                applyStimulus_pixel(3'($urandom_range(0, 7)), 7'h7F, 1'b1);
            else
                applyStimulus_pixel(3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), 1'b1);
        end
        applyStimulus_pixel(3'd0, 7'd0, 1'b0);

        // Write, commit, swap at vblank
        applyStimulus_cpu(1'b1, 7'h05, 8'h01, lat);
        check("ack_latency", lat, 2);
        applyStimulus_cpu(1'b0, 7'h05, 8'h00, lat);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        applyStimulus_vblank();
        repeat (130) tick();
        checkOutput_lookup(3'd0, 7'h28);
        applyStimulus_cpu(1'b0, 7'h05, 8'h00, lat);

        // Writes without commit: vblanks must not change the live table
        for (int i = 0; i < 6; i++) begin
            waddr[i] = 7'($urandom_range(0, 127));
            applyStimulus_cpu(1'b1, waddr[i], 8'($urandom_range(1, 255)), lat);
        end
        repeat (3) begin
            applyStimulus_vblank();
            repeat (5) tick();
        end
        for (int i = 0; i < 6; i++)
            checkOutput_lookup(waddr[i][6:4], {waddr[i][3:0], 3'($urandom_range(0, 7))});

        // Commit and LVBL fall in the same cycle; a CPU read during COPY waits for busy to drop
        commit = 1'b1;
        LVBL   = 1'b0;
        tick();
        commit = 1'b0;
        tick();
        LVBL   = 1'b1;
        tick();
        b = m_busy;
        applyStimulus_cpu(1'b0, waddr[0], 8'h00, lat);
        check("ack_after_copy", lat, b + 2);
        for (int i = 0; i < 6; i++)
            checkOutput_lookup(waddr[i][6:4], {waddr[i][3:0], 3'($urandom_range(0, 7))});

        // Vblank during FILL with commit already pending: swap deferred to the next vblank
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        repeat (10) tick();
        applyStimulus_vblank();
        repeat (110) tick();
        applyStimulus_cpu(1'b1, 7'h0F, 8'h00, lat);
        checkOutput_lookup(3'd0, 7'h7F);
        applyStimulus_vblank();
        repeat (130) tick();
        checkOutput_lookup(3'd0, 7'h7F);

        // Reset in the middle of COPY restores the default table and clears pending
        applyStimulus_cpu(1'b1, 7'h2A, 8'hFF, lat);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        applyStimulus_vblank();
        repeat (20) tick();
        rst = 1'b1;
        #1;
        checkOutput_reset_values("mid_copy");
        tick();
        rst = 1'b0;
        repeat (128) tick();
        applyStimulus_vblank();
        repeat (5) tick();
        checkOutput_lookup(3'd0, 7'h7F);
        checkOutput_lookup(3'd2, {4'hA, 3'd3});
        checkOutput_lookup(3'd0, 7'h28);
        applyStimulus_cpu(1'b0, 7'h2A, 8'h00, lat);
        repeat (4) tick();

        check("cpu_queue_drained", cpu_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
